uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin arbiter that shares one UART_TX serializer among NUM_REQ byte sources.
//  It picks one pending requester, hands that byte to the transmitter with a one-cycle
//  data-valid, then tracks the TX active/done handshake until the frame completes.
//  Sits between the per-source packet logic and the single UART TX pin driver.
// PARAMETERS
//  NUM_REQ       4     number of requesters (2..8)
//  IDX_W         2     width of requester index, = clog2(NUM_REQ)
//  TIMEOUT_CLKS  4096  watchdog limit in clocks (only with UART_ARB_TIMEOUT_EN); must exceed 10*CLKS_PER_BIT
// PORTS
//  i_Clock       in   1            system clock; all logic on rising edge
//  i_Reset       in   1            synchronous, active-high reset
//  i_Req         in   NUM_REQ      per-source request; held high until matching o_Grant bit
//  i_Req_Byte    in   8*NUM_REQ    per-source byte, source k at [8k+7:8k]; stable while i_Req[k]=1
//  o_Grant       out  NUM_REQ      one-hot, one-cycle pulse: byte of that source consumed
//  o_TX_DV       out  1            one-cycle pulse to transmitter data-valid
//  o_TX_Byte     out  8            byte to transmitter; registered, valid with o_TX_DV
//  i_TX_Active   in   1            transmitter busy flag
//  i_TX_Done     in   1            transmitter done flag (high 2 cycles at frame end)
//  o_Busy        out  1            high in every state except IDLE
//  o_Last_Src    out  IDX_W        index of most recently granted source
//  o_Timeout     out  1            one-cycle pulse on watchdog abort (0 when macro off)
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE; o_Grant=0, o_TX_DV=0, o_TX_Byte=0, o_Busy=0, o_Timeout=0,
//    o_Last_Src=NUM_REQ-1 (source 0 has highest priority first). Reset mid-frame aborts at once; the TX is not reset.
//  - States: IDLE -> ISSUE -> WAIT_ACT -> WAIT_DONE -> DRAIN -> IDLE.
//  - IDLE: if |i_Req and i_TX_Active=0 and i_TX_Done=0: winner = first set bit scanning
//    o_Last_Src+1, +2, ... modulo NUM_REQ; latch winner index and its byte into o_TX_Byte; -> ISSUE.
//  - ISSUE (1 cycle): o_TX_DV=1, o_Grant[winner]=1, o_Last_Src<=winner; -> WAIT_ACT.
//    Latency: request seen in IDLE cycle N -> DV/grant in cycle N+1.
//  - WAIT_ACT: wait for i_TX_Active=1 -> WAIT_DONE.
//  - WAIT_DONE: wait for i_TX_Done=1 -> DRAIN. (Active falls on the same edge Done rises.)
//  - DRAIN: wait for i_TX_Done=0 -> IDLE. No new DV is issued while Done is still high.
//  - Back-to-back: with a continuous request, the next ISSUE is 2 cycles after Done falls (IDLE, ISSUE).
//  - Simultaneous requests: exactly one grant per frame; the winner rotates strictly round-robin.
//  - A request that appears during a frame waits; it is never lost and never double-granted.
//  - A request deasserted after its IDLE capture still completes and still receives its grant pulse.
//  - o_Grant is always one-hot or zero and high only in ISSUE; o_TX_DV == |o_Grant.
//  - o_TX_Byte holds its value until the next IDLE capture.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined:
//    - Counter clears in ISSUE and increments in WAIT_ACT, WAIT_DONE and DRAIN.
//    - At count TIMEOUT_CLKS-1: o_Timeout pulses 1 cycle, state -> IDLE, o_Last_Src keeps the aborted index.
//    - IDLE still requires Active=0 and Done=0 before issuing.
//  Undefined: no counter, o_Timeout tied 0, waits indefinitely.
// TESTING (real UART_TX, CLKS_PER_BIT=8, NUM_REQ=4)
//  1. Reset, then i_Req=4'b0001, byte0=8'hA5 -> DV+Grant=0001 one cycle after request;
//     serial line 0,1,0,1,0,0,1,0,1,1 (LSB first); o_Busy falls after Done falls.
//  2. i_Req=4'b1111 held, bytes 11/22/33/44 -> grant order 0,1,2,3,0; one DV per frame; no DV while Done=1.
//  3. Last_Src=1, i_Req=4'b1001 -> source 3 granted before source 0.
//  4. i_Req[2] asserted in mid-frame -> granted 2 cycles after current Done falls; byte intact.
//  5. i_Reset pulsed 1 cycle in WAIT_DONE -> next cycle all outputs at reset values; re-arbitrates
//     only after TX Active/Done are both 0.
//  6. With UART_ARB_TIMEOUT_EN, TIMEOUT_CLKS=64, i_TX_Active stubbed to 0 -> o_Timeout pulse
//     64 cycles after ISSUE, state IDLE; without macro o_Timeout stays 0 and o_Busy stays 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART TX serializer among
// NUM_REQ byte sources. Issues a one-cycle DV/grant per frame and follows the
// transmitter active/done handshake until the frame is fully drained.
// Optional watchdog abort enabled with macro UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned IDX_W        = 2,
   parameter int unsigned TIMEOUT_CLKS = 4096
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic [NUM_REQ-1:0]   i_Req,
   input  logic [8*NUM_REQ-1:0] i_Req_Byte,
   output logic [NUM_REQ-1:0]   o_Grant,
   output logic                 o_TX_DV,
   output logic [7:0]           o_TX_Byte,
   input  logic                 i_TX_Active,
   input  logic                 i_TX_Done,
   output logic                 o_Busy,
   output logic [IDX_W-1:0]     o_Last_Src,
   output logic                 o_Timeout
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACT,
      WAIT_DONE,
      DRAIN
   } state_t;

   state_t           r_State;
   state_t           w_Next;
   logic [IDX_W-1:0] r_Winner;
   logic [IDX_W-1:0] w_Pick;
   logic [IDX_W-1:0] w_Idx;
   logic             w_Found;
   logic             w_Go;
   logic             w_Waiting;
   logic             w_Timeout;

   assign w_Waiting = (r_State == WAIT_ACT) || (r_State == WAIT_DONE) || (r_State == DRAIN);
   assign w_Go      = w_Found && !i_TX_Active && !i_TX_Done;

   // Round-robin search: first pending request after the last granted source
   always_comb begin
      w_Pick  = '0;
      w_Idx   = '0;
      w_Found = 1'b0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         w_Idx = IDX_W'((32'(o_Last_Src) + i) % NUM_REQ);
         if (!w_Found && i_Req[w_Idx]) begin
            w_Found = 1'b1;
            w_Pick  = w_Idx;
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS) + 1;

   logic [CNT_W-1:0] r_Count;

   // Watchdog counter: cleared on issue, runs while waiting on the transmitter
   always_ff @(posedge i_Clock) begin
      if (i_Reset)
         r_Count <= '0;
      else if (r_State == ISSUE)
         r_Count <= '0;
      else if (w_Waiting)
         r_Count <= r_Count + 1'b1;
   end

   assign w_Timeout = w_Waiting && (r_Count == CNT_W'(TIMEOUT_CLKS - 1));
`else
   assign w_Timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge i_Clock) begin
      if (i_Reset)
         r_State <= IDLE;
      else
         r_State <= w_Next;
   end

   // Next-state logic; watchdog abort takes priority in every wait state
   always_comb begin
      w_Next = r_State;
      case (r_State)
         IDLE:      if (w_Go) w_Next = ISSUE;
         ISSUE:     w_Next = WAIT_ACT;
         WAIT_ACT:  if (w_Timeout) w_Next = IDLE;
                    else if (i_TX_Active) w_Next = WAIT_DONE;
         WAIT_DONE: if (w_Timeout) w_Next = IDLE;
                    else if (i_TX_Done) w_Next = DRAIN;
         DRAIN:     if (w_Timeout) w_Next = IDLE;
                    else if (!i_TX_Done) w_Next = IDLE;
         default:   w_Next = IDLE;
      endcase
   end

   // Winner/byte capture in IDLE, last-source update in ISSUE
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_Winner   <= '0;
         o_TX_Byte  <= '0;
         o_Last_Src <= IDX_W'(NUM_REQ - 1);
      end else begin
         if (r_State == IDLE && w_Go) begin
            r_Winner  <= w_Pick;
            o_TX_Byte <= i_Req_Byte[8*w_Pick +: 8];
         end
         if (r_State == ISSUE)
            o_Last_Src <= r_Winner;
      end
   end

   // Outputs decoded from state
   always_comb begin
      o_Grant   = '0;
      o_TX_DV   = 1'b0;
      o_Busy    = (r_State != IDLE);
      o_Timeout = w_Timeout;
      if (r_State == ISSUE) begin
         o_Grant[r_Winner] = 1'b1;
         o_TX_DV           = 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CLKS=64). The
// transmitter handshake is driven directly by the stimulus sequence.
module tb_uart_tx_arbiter;

   logic        i_Clock = 1'b0;
   logic        i_Reset = 1'b1;
   logic [3:0]  i_Req = '0;
   logic [31:0] i_Req_Byte = '0;
   logic [3:0]  o_Grant;
   logic        o_TX_DV;
   logic [7:0]  o_TX_Byte;
   logic        i_TX_Active = 1'b0;
   logic        i_TX_Done = 1'b0;
   logic        o_Busy;
   logic [1:0]  o_Last_Src;
   logic        o_Timeout;

   int n_tests = 0;
   int n_fail  = 0;
   logic inv_on = 1'b0;
   logic early;

   uart_tx_arbiter #(
      .NUM_REQ(4),
      .IDX_W(2),
      .TIMEOUT_CLKS(64)
   ) dut (
      .i_Clock(i_Clock),
      .i_Reset(i_Reset),
      .i_Req(i_Req),
      .i_Req_Byte(i_Req_Byte),
      .o_Grant(o_Grant),
      .o_TX_DV(o_TX_DV),
      .o_TX_Byte(o_TX_Byte),
      .i_TX_Active(i_TX_Active),
      .i_TX_Done(i_TX_Done),
      .o_Busy(o_Busy),
      .o_Last_Src(o_Last_Src),
      .o_Timeout(o_Timeout)
   );

   always #5 i_Clock = ~i_Clock;

   task automatic tick();
      @(posedge i_Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Grant is one-hot-or-zero and DV mirrors it
   always @(negedge i_Clock) begin
      if (inv_on) begin
         n_tests++;
         assert ((o_TX_DV === |o_Grant) && $onehot0(o_Grant)) else begin
            n_fail++;
            $error("FAIL invariant: grant %b dv %b", o_Grant, o_TX_DV);
         end
      end
   end

   // Called while DUT is in ISSUE; runs one frame and returns with DUT in IDLE
   task automatic do_frame(input logic [7:0] b);
      i_TX_Active = 1'b1;
      tick();
      chk("wact_dv", {31'b0, o_TX_DV}, 32'd0);
      tick();
      chk("wdone_busy", {31'b0, o_Busy}, 32'd1);
      chk("hold_byte", {24'b0, o_TX_Byte}, {24'b0, b});
      i_TX_Active = 1'b0;
      i_TX_Done   = 1'b1;
      tick();
      chk("drain_dv0", {31'b0, o_TX_DV}, 32'd0);
      tick();
      chk("drain_dv1", {31'b0, o_TX_DV}, 32'd0);
      chk("drain_busy", {31'b0, o_Busy}, 32'd1);
      i_TX_Done = 1'b0;
      tick();
      chk("idle_busy", {31'b0, o_Busy}, 32'd0);
      chk("idle_dv", {31'b0, o_TX_DV}, 32'd0);
   endtask

   task automatic do_reset();
      i_Reset = 1'b1;
      tick();
      i_Reset = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_g [5];
      logic [7:0] exp_b [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

      // Reset values
      tick();
      do_reset();
      inv_on = 1'b1;
      chk("rst_grant", {28'b0, o_Grant}, 32'd0);
      chk("rst_dv", {31'b0, o_TX_DV}, 32'd0);
      chk("rst_byte", {24'b0, o_TX_Byte}, 32'd0);
      chk("rst_busy", {31'b0, o_Busy}, 32'd0);
      chk("rst_tmo", {31'b0, o_Timeout}, 32'd0);
      chk("rst_last", {30'b0, o_Last_Src}, 32'd3);

      // 1: single request, one-cycle latency
      i_Req_Byte = 32'h000000A5;
      i_Req      = 4'b0001;
      tick();
      chk("t1_dv", {31'b0, o_TX_DV}, 32'd1);
      chk("t1_grant", {28'b0, o_Grant}, 32'b0001);
      chk("t1_byte", {24'b0, o_TX_Byte}, 32'hA5);
      i_Req = 4'b0000;
      do_frame(8'hA5);
      chk("t1_last", {30'b0, o_Last_Src}, 32'd0);

      // 2: all requesting, strict rotation from source 0
      do_reset();
      i_Req_Byte = 32'h44332211;
      i_Req      = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t2_grant", {28'b0, o_Grant}, {28'b0, exp_g[k]});
         chk("t2_byte", {24'b0, o_TX_Byte}, {24'b0, exp_b[k]});
         if (k == 4) i_Req = 4'b0000;
         do_frame(exp_b[k]);
      end

      // 3: Last_Src=1 with requests 3 and 0 -> 3 first
      i_Req = 4'b0010;
      tick();
      chk("t3_g1", {28'b0, o_Grant}, 32'b0010);
      i_Req = 4'b1001;
      do_frame(8'h22);
      chk("t3_last", {30'b0, o_Last_Src}, 32'd1);
      tick();
      chk("t3_g3", {28'b0, o_Grant}, 32'b1000);
      chk("t3_b3", {24'b0, o_TX_Byte}, 32'h44);
      i_Req = 4'b0001;
      do_frame(8'h44);
      tick();
      chk("t3_g0", {28'b0, o_Grant}, 32'b0001);
      i_Req = 4'b0000;
      do_frame(8'h11);

      // 4: request arriving mid-frame waits for the drain
      i_Req_Byte = 32'h443C2211;
      i_Req      = 4'b0001;
      tick();
      chk("t4_g0", {28'b0, o_Grant}, 32'b0001);
      i_Req       = 4'b0000;
      i_TX_Active = 1'b1;
      tick();
      tick();
      i_Req = 4'b0100;
      tick();
      chk("t4_mid_dv", {31'b0, o_TX_DV}, 32'd0);
      i_TX_Active = 1'b0;
      i_TX_Done   = 1'b1;
      tick();
      chk("t4_drain_dv", {31'b0, o_TX_DV}, 32'd0);
      tick();
      chk("t4_drain_dv2", {31'b0, o_TX_DV}, 32'd0);
      i_TX_Done = 1'b0;
      tick();
      chk("t4_idle_dv", {31'b0, o_TX_DV}, 32'd0);
      tick();
      chk("t4_g2", {28'b0, o_Grant}, 32'b0100);
      chk("t4_b2", {24'b0, o_TX_Byte}, 32'h3C);
      i_Req = 4'b0000;
      do_frame(8'h3C);

      // 5: reset in WAIT_DONE; no re-issue until TX idle
      i_Req = 4'b0010;
      tick();
      chk("t5_g1", {28'b0, o_Grant}, 32'b0010);
      i_Req       = 4'b0000;
      i_TX_Active = 1'b1;
      tick();
      tick();
      i_Reset = 1'b1;
      tick();
      i_Reset = 1'b0;
      chk("t5_busy", {31'b0, o_Busy}, 32'd0);
      chk("t5_byte", {24'b0, o_TX_Byte}, 32'd0);
      chk("t5_last", {30'b0, o_Last_Src}, 32'd3);
      chk("t5_grant", {28'b0, o_Grant}, 32'd0);
      i_Req = 4'b0001;
      tick();
      chk("t5_act_dv", {31'b0, o_TX_DV}, 32'd0);
      i_TX_Active = 1'b0;
      i_TX_Done   = 1'b1;
      tick();
      chk("t5_done_dv", {31'b0, o_TX_DV}, 32'd0);
      tick();
      chk("t5_done_dv2", {31'b0, o_Busy}, 32'd0);
      i_TX_Done = 1'b0;
      tick();
      chk("t5_reissue", {28'b0, o_Grant}, 32'b0001);
      i_Req = 4'b0000;
      do_frame(8'h11);

      // 6: transmitter never goes active
      i_Req = 4'b0100;
      tick();
      chk("t6_g2", {28'b0, o_Grant}, 32'b0100);
      i_Req = 4'b0000;
      early = 1'b0;
      for (int k = 0; k < 63; k++) begin
         tick();
         if (o_Timeout !== 1'b0 || o_Busy !== 1'b1) early = 1'b1;
      end
      chk("t6_early", {31'b0, early}, 32'd0);
      tick();
`ifdef UART_ARB_TIMEOUT_EN
      chk("t6_tmo", {31'b0, o_Timeout}, 32'd1);
      chk("t6_busy", {31'b0, o_Busy}, 32'd1);
      tick();
      chk("t6_tmo_end", {31'b0, o_Timeout}, 32'd0);
      chk("t6_idle", {31'b0, o_Busy}, 32'd0);
      chk("t6_last", {30'b0, o_Last_Src}, 32'd2);
`else
      chk("t6_tmo", {31'b0, o_Timeout}, 32'd0);
      chk("t6_busy", {31'b0, o_Busy}, 32'd1);
      tick();
      chk("t6_tmo2", {31'b0, o_Timeout}, 32'd0);
      chk("t6_busy2", {31'b0, o_Busy}, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
